switch_event_queue: RTL and testbench
=====================================

Name: switch_event_queue

Overview:
- Consumes the debounced 18-bit switch bus from the switch debounce bank.
- Turns every level change into an event record {switch index, new level}.
- Buffers events in a small first-word-fall-through FIFO, read by the game/control FSM through a valid/ready handshake.
- If several switches change in one cycle, their events are serialized lowest index first, one per cycle.

Parameters:
- W, 18: number of switch inputs.
- IDX_W, 5: width of the event index field; 2^IDX_W >= W.
- DEPTH, 8: FIFO entries; power of two, >= 2.
- CNT_W, 4: count width; equals log2(DEPTH)+1.

Ports:
- clk  in  1  system clock.
- n_reset  in  1  synchronous, active-low reset.
- sw_db  in  W  debounced switch levels; already synchronous to clk.
- ev_valid  out  1  FIFO head holds a valid event.
- ev_ready  in  1  consumer accepts the head event this cycle.
- ev_idx  out  IDX_W  switch index of the head event.
- ev_level  out  1  switch level reported by the head event.
- count  out  CNT_W  number of events held in the FIFO, 0..DEPTH.
- overflow  out  1  sticky flag: an event was coalesced (lost).
- clr_overflow  in  1  clears overflow.

Behaviour:
Clocking and reset:
- Clock is clk. Reset is n_reset, synchronous, active-low.
- While n_reset=0: sw_prev <= sw_db every cycle, so no events are generated at reset release. Also pending <= 0, wr_ptr <= 0, rd_ptr <= 0, count <= 0, overflow <= 0.
- Reset values of outputs: ev_valid=0, ev_idx=0, ev_level=0, count=0, overflow=0.
- Reset asserted mid-operation discards all FIFO contents and pending changes at that edge.

Edge detection:
- chg = sw_db ^ sw_prev (combinational).
- sw_prev <= sw_db every cycle when not in reset.
- pending[i] <= (pending[i] & ~served[i]) | chg[i].

Coalescing and overflow:
- If chg[i]=1 while pending[i]=1 and bit i is not served this cycle, the pending bit stays set and overflow <= 1.
- Only one event is emitted for that switch, and it carries the level at the time it is served.
- If chg[i]=1 in the same cycle that bit i is served, pending[i] stays 1 and a new event follows. overflow is not set.
- clr_overflow=1 clears overflow. If a set condition occurs in the same cycle, set wins.

Arbitration:
- sel = lowest index i with pending[i]=1.
- push = (pending != 0) and (count < DEPTH or pop).
- On push:
  - write {sel, sw_prev[sel]} at wr_ptr; this is the level registered at serve time;
  - clear pending[sel];
  - wr_ptr <= wr_ptr+1 mod DEPTH.
- When the FIFO is full and there is no pop, pending bits are held. Nothing is lost except by coalescing.

FIFO and handshake:
- First-word-fall-through.
- ev_valid = (count != 0). ev_idx and ev_level are driven from the entry at rd_ptr.
- pop = ev_valid & ev_ready; on pop, rd_ptr <= rd_ptr+1 mod DEPTH.
- ev_ready while ev_valid=0 has no effect.
- count updates:
  - count+1 on push only;
  - count-1 on pop only;
  - unchanged on both or neither.
- Push while full is legal only together with a pop.
- Head outputs stay stable while ev_valid=1 and ev_ready=0.

Latency:
- If sw_db changes before edge k, pending is set at edge k.
- With an empty FIFO and the bit lowest pending, the event is written at edge k+1 and ev_valid=1 after edge k+1.
- Minimum latency is 2 cycles.
- Throughput is one event per cycle.

Test Plan:
- Hold sw_db=0x2A5A3 through reset, then release -> ev_valid stays 0 and count=0 for 20 cycles.
- With FIFO empty and ev_ready=1, toggle sw_db[3] 0->1 -> ev_valid=1 exactly 2 cycles after the change, with ev_idx=3, ev_level=1. Popped the next cycle; count returns to 0.
- With ev_ready=0, toggle bits 17, 5 and 0 in the same cycle -> count reaches 3 on 3 consecutive cycles. Raising ev_ready drains in index order 0, 5, 17, all with ev_level=1; overflow=0.
- With ev_ready=0, toggle 10 distinct switches in one cycle -> count saturates at 8 and 2 bits remain pending. Raising ev_ready continuously delivers all 10 events in ascending index order; overflow=0.
- With ev_ready=0 and the FIFO full, toggle bit 2 0->1, then 1->0 two cycles later while it is still pending -> overflow=1, and a single event {2, 0} is delivered after draining. Pulse clr_overflow -> overflow=0.
- Hold the FIFO at count=8 with a pending bit and ev_ready=1 -> push and pop occur each cycle, count stays 8 until pending empties, and pointers wrap correctly (event order preserved across the wrap).

Source files
------------

// File: rtl/switch_event_queue.sv
// Turns level changes on the debounced switch bus into {index, level} events
// and queues them in a small first-word-fall-through FIFO behind a valid/ready port.
module switch_event_queue #(
    parameter int unsigned W     = 18,
    parameter int unsigned IDX_W = 5,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [W-1:0]     sw_db,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDX_W-1:0] ev_idx,
    output logic             ev_level,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    input  logic             clr_overflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [IDX_W:0] entry_t;

    logic [W-1:0]     sw_prev_q;
    logic [W-1:0]     pending_q;
    logic [W-1:0]     pending_d;
    logic [W-1:0]     chg;
    logic [W-1:0]     served;
    logic [IDX_W-1:0] sel;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             full;
    logic             push;
    logic             pop;
    logic             lost;
    entry_t           head;
    entry_t           mem_q [DEPTH];

    assign chg = sw_db ^ sw_prev_q;

    // Priority pick: lowest pending index wins.
    always_comb begin
        sel = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

    assign full     = (count_q == CNT_W'(DEPTH));
    assign ev_valid = (count_q != '0);
    assign pop      = ev_valid & ev_ready;
    assign push     = (|pending_q) & (~full | pop);
    assign served   = push ? (W'(1) << sel) : '0;

    // A change on a bit that is already waiting and not being served this cycle
    // merges into the existing request; the intermediate level is lost.
    assign lost = |(chg & pending_q & ~served);

    always_comb begin
        pending_d  = (pending_q & ~served) | chg;
        overflow_d = overflow_q;
        if (lost) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        sw_prev_q <= sw_db;
        if (!n_reset) begin
            pending_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // The stored level is the registered one, i.e. the level at serve time.
    always_ff @(posedge clk) begin
        if (n_reset && push) begin
            mem_q[wr_ptr_q] <= {sel, sw_prev_q[sel]};
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign ev_idx   = ev_valid ? head[IDX_W:1] : '0;
    assign ev_level = ev_valid & head[0];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_switch_event_queue.sv
// Directed and randomized bench for switch_event_queue against a queue-based
// behavioural model of the event stream.
module tb_switch_event_queue;

    localparam int unsigned W     = 18;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             n_reset;
    logic [W-1:0]     sw_db;
    logic             ev_valid;
    logic             ev_ready;
    logic [IDX_W-1:0] ev_idx;
    logic             ev_level;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             clr_overflow;

    int checks = 0;
    int errors = 0;

    // Model state: previous levels, outstanding changes, queued events, sticky flag.
    logic [W-1:0]     m_prev;
    logic [W-1:0]     m_pend;
    logic [IDX_W:0]   m_q[$];
    logic             m_ovf;

    switch_event_queue #(
        .W    (W),
        .IDX_W(IDX_W),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .sw_db       (sw_db),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_idx      (ev_idx),
        .ev_level    (ev_level),
        .count       (count),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        logic [IDX_W:0] hd;
        hd = (m_q.size() != 0) ? m_q[0] : '0;
        check("m_valid", 32'(ev_valid), 32'(m_q.size() != 0));
        check("m_idx", 32'(ev_idx), 32'(hd[IDX_W:1]));
        check("m_level", 32'(ev_level), 32'(hd[0]));
        check("m_count", 32'(count), 32'(m_q.size()));
        check("m_ovf", 32'(overflow), 32'(m_ovf));
    endtask

    // Applies one clock edge of the event-queue rules to the model.
    task automatic model_update();
        int         sel;
        bit         pop;
        logic [W-1:0] srv;
        logic [W-1:0] chg;
        if (!n_reset) begin
            m_prev = sw_db;
            m_pend = '0;
            m_q.delete();
            m_ovf  = 1'b0;
        end else begin
            pop = (m_q.size() != 0) && ev_ready;
            sel = -1;
            if (m_pend != 0 && (m_q.size() < DEPTH || pop)) begin
                for (int i = 0; i < W; i++) begin
                    if (m_pend[i]) begin
                        sel = i;
                        break;
                    end
                end
            end
            srv = '0;
            if (sel >= 0) srv[sel] = 1'b1;
            chg = sw_db ^ m_prev;
            if (pop) void'(m_q.pop_front());
            if (sel >= 0) m_q.push_back({IDX_W'(sel), m_prev[sel]});
            if ((chg & m_pend & ~srv) != 0) m_ovf = 1'b1;
            else if (clr_overflow) m_ovf = 1'b0;
            m_pend = (m_pend & ~srv) | chg;
            m_prev = sw_db;
        end
    endtask

    task automatic step(input bit do_cmp);
        if (do_cmp) compare_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        int exp3[3];
        int ten[10];
        exp3 = '{0, 5, 17};
        ten  = '{1, 2, 4, 6, 7, 8, 9, 10, 11, 12};
        m_prev = '0;
        m_pend = '0;
        m_ovf  = 1'b0;

        // Reset with a non-zero bus: release must not produce events.
        n_reset      = 1'b0;
        sw_db        = 18'h2A5A3;
        ev_ready     = 1'b0;
        clr_overflow = 1'b0;
        step(0);
        step(1);
        step(1);
        n_reset = 1'b1;
        repeat (20) step(1);
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        n_reset = 1'b0;
        sw_db   = '0;
        step(1);
        n_reset = 1'b1;
        step(1);

        // Single toggle: two-cycle latency, then popped.
        ev_ready = 1'b1;
        sw_db[3] = 1'b1;
        step(1);
        check("lat_early", 32'(ev_valid), 32'd0);
        step(1);
        check("lat_valid", 32'(ev_valid), 32'd1);
        check("lat_idx", 32'(ev_idx), 32'd3);
        check("lat_level", 32'(ev_level), 32'd1);
        step(1);
        check("lat_count", 32'(count), 32'd0);

        // Three simultaneous changes serialized lowest first.
        ev_ready = 1'b0;
        sw_db[0]  = 1'b1;
        sw_db[5]  = 1'b1;
        sw_db[17] = 1'b1;
        step(1);
        check("ser_cnt0", 32'(count), 32'd0);
        step(1);
        check("ser_cnt1", 32'(count), 32'd1);
        step(1);
        check("ser_cnt2", 32'(count), 32'd2);
        step(1);
        check("ser_cnt3", 32'(count), 32'd3);
        ev_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("ser_idx", 32'(ev_idx), 32'(exp3[k]));
            check("ser_level", 32'(ev_level), 32'd1);
            step(1);
        end
        check("ser_empty", 32'(count), 32'd0);
        check("ser_ovf", 32'(overflow), 32'd0);

        // Ten changes: FIFO saturates, remainder held, push+pop at full.
        ev_ready = 1'b0;
        for (int k = 0; k < 10; k++) sw_db[ten[k]] = 1'b1;
        repeat (9) step(1);
        check("sat_cnt", 32'(count), 32'd8);
        step(1);
        check("sat_hold", 32'(count), 32'd8);
        ev_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("sat_valid", 32'(ev_valid), 32'd1);
            check("sat_idx", 32'(ev_idx), 32'(ten[k]));
            if (k <= 2) check("sat_full", 32'(count), 32'd8);
            step(1);
        end
        check("sat_empty", 32'(count), 32'd0);
        check("sat_ovf", 32'(overflow), 32'd0);

        // Coalescing while full sets overflow and keeps one event.
        sw_db[2] = 1'b0;
        repeat (3) step(1);
        check("co_pre", 32'(count), 32'd0);
        ev_ready = 1'b0;
        sw_db[13] = 1'b1;
        sw_db[14] = 1'b1;
        sw_db[15] = 1'b1;
        sw_db[16] = 1'b1;
        sw_db[0]  = 1'b0;
        sw_db[1]  = 1'b0;
        sw_db[3]  = 1'b0;
        sw_db[4]  = 1'b0;
        repeat (9) step(1);
        check("co_full", 32'(count), 32'd8);
        sw_db[2] = 1'b1;
        step(1);
        step(1);
        check("co_noovf", 32'(overflow), 32'd0);
        sw_db[2] = 1'b0;
        step(1);
        check("co_ovf", 32'(overflow), 32'd1);
        ev_ready = 1'b1;
        repeat (8) step(1);
        check("co_idx", 32'(ev_idx), 32'd2);
        check("co_level", 32'(ev_level), 32'd0);
        step(1);
        check("co_empty", 32'(count), 32'd0);
        check("co_sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        check("co_clr", 32'(overflow), 32'd0);

        // Randomized traffic: back-pressure heavy first, then mostly ready.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) sw_db ^= W'(1) << $urandom_range(0, W - 1);
            if ($urandom_range(0, 15) == 0) sw_db ^= W'($urandom) & W'($urandom);
            ev_ready     = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr_overflow = ($urandom_range(0, 11) == 0);
            n_reset      = ($urandom_range(0, 149) != 0);
            step(1);
        end
        n_reset      = 1'b1;
        clr_overflow = 1'b0;
        step(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
